// File: rtl/traffic_pkg.sv
// Shared phase encodings, default timing constants and lamp payload type
// for the two-way intersection sequencer.
package traffic_pkg;

    localparam int unsigned PHASE_W = 3;

    localparam logic [PHASE_W-1:0] NS_GRN = 3'd0;
    localparam logic [PHASE_W-1:0] NS_YEL = 3'd1;
    localparam logic [PHASE_W-1:0] RED_A  = 3'd2;
    localparam logic [PHASE_W-1:0] EW_GRN = 3'd3;
    localparam logic [PHASE_W-1:0] EW_YEL = 3'd4;
    localparam logic [PHASE_W-1:0] RED_B  = 3'd5;

    localparam int unsigned DEF_NS_GREEN_CYC = 32;
    localparam int unsigned DEF_EW_GREEN_CYC = 16;
    localparam int unsigned DEF_YELLOW_CYC   = 4;
    localparam int unsigned DEF_ALLRED_CYC   = 2;
    localparam int unsigned DEF_TMR_W        = 6;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    localparam lamp_t LAMP_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
    localparam lamp_t LAMP_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
    localparam lamp_t LAMP_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

endpackage

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// Phase timer: counts cycles spent in the current phase, clears on phase
// entry and holds once it reaches the supplied limit.
module phase_timer #(
    parameter int unsigned TMR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [TMR_W-1:0] limit,
    output logic [TMR_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count != limit) begin
            count <= count + TMR_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-way intersection sequencer: phase FSM, vehicle request latches and
// registered lamp decode around a single shared phase timer.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned NS_GREEN_CYC = DEF_NS_GREEN_CYC,
    parameter int unsigned EW_GREEN_CYC = DEF_EW_GREEN_CYC,
    parameter int unsigned YELLOW_CYC   = DEF_YELLOW_CYC,
    parameter int unsigned ALLRED_CYC   = DEF_ALLRED_CYC,
    parameter int unsigned TMR_W        = DEF_TMR_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_NS_vehicle_detect,
    input  logic               i_EW_vehicle_detect,
    output logic               o_NS_red,
    output logic               o_NS_yellow,
    output logic               o_NS_green,
    output logic               o_EW_red,
    output logic               o_EW_yellow,
    output logic               o_EW_green,
    output logic [PHASE_W-1:0] o_phase,
    output logic [TMR_W-1:0]   o_timer
);

    localparam logic [TMR_W-1:0] NS_LIM  = TMR_W'(NS_GREEN_CYC - 1);
    localparam logic [TMR_W-1:0] EW_LIM  = TMR_W'(EW_GREEN_CYC - 1);
    localparam logic [TMR_W-1:0] YEL_LIM = TMR_W'(YELLOW_CYC - 1);
    localparam logic [TMR_W-1:0] AR_LIM  = TMR_W'(ALLRED_CYC - 1);

    logic [PHASE_W-1:0] state_q;
    logic [PHASE_W-1:0] state_nxt_c;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   tmr_lim_c;
    logic               tmr_clr_c;
    logic               ns_req_q;
    logic               ew_req_q;
    logic               ns_entry_c;
    logic               ew_entry_c;
    lamp_t              ns_lamp_q;
    lamp_t              ew_lamp_q;
    lamp_t              ns_lamp_nxt_c;
    lamp_t              ew_lamp_nxt_c;

    phase_timer #(
        .TMR_W (TMR_W)
    ) u_phase_timer (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (tmr_clr_c),
        .limit (tmr_lim_c),
        .count (timer_q)
    );

    // Next phase; greens only yield once minimum time is up and the other side waits
    always_comb begin
        state_nxt_c = state_q;
        tmr_lim_c   = '0;
        case (state_q)
            NS_GRN: begin
                tmr_lim_c = NS_LIM;
                if (timer_q == NS_LIM && ew_req_q) state_nxt_c = NS_YEL;
            end
            NS_YEL: begin
                tmr_lim_c = YEL_LIM;
                if (timer_q == YEL_LIM) state_nxt_c = RED_A;
            end
            RED_A: begin
                tmr_lim_c = AR_LIM;
                if (timer_q == AR_LIM) state_nxt_c = EW_GRN;
            end
            EW_GRN: begin
                tmr_lim_c = EW_LIM;
                if (timer_q == EW_LIM && ns_req_q) state_nxt_c = EW_YEL;
            end
            EW_YEL: begin
                tmr_lim_c = YEL_LIM;
                if (timer_q == YEL_LIM) state_nxt_c = RED_B;
            end
            RED_B: begin
                tmr_lim_c = AR_LIM;
                if (timer_q == AR_LIM) state_nxt_c = NS_GRN;
            end
            default: state_nxt_c = NS_GRN;
        endcase

        tmr_clr_c  = (state_nxt_c != state_q);
        ns_entry_c = tmr_clr_c && (state_nxt_c == NS_GRN);
        ew_entry_c = tmr_clr_c && (state_nxt_c == EW_GRN);

        ns_lamp_nxt_c = LAMP_RED;
        ew_lamp_nxt_c = LAMP_RED;
        case (state_nxt_c)
            NS_GRN:  ns_lamp_nxt_c = LAMP_GREEN;
            NS_YEL:  ns_lamp_nxt_c = LAMP_YELLOW;
            EW_GRN:  ew_lamp_nxt_c = LAMP_GREEN;
            EW_YEL:  ew_lamp_nxt_c = LAMP_YELLOW;
            default: ;
        endcase
    end

    // Detect has priority over the clear that happens on green entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= NS_GRN;
            ns_req_q  <= 1'b0;
            ew_req_q  <= 1'b0;
            ns_lamp_q <= LAMP_GREEN;
            ew_lamp_q <= LAMP_RED;
        end else begin
            state_q   <= state_nxt_c;
            ns_req_q  <= i_NS_vehicle_detect | (ns_req_q & ~ns_entry_c);
            ew_req_q  <= i_EW_vehicle_detect | (ew_req_q & ~ew_entry_c);
            ns_lamp_q <= ns_lamp_nxt_c;
            ew_lamp_q <= ew_lamp_nxt_c;
        end
    end

    assign o_phase     = state_q;
    assign o_timer     = timer_q;
    assign o_NS_red    = ns_lamp_q.red;
    assign o_NS_yellow = ns_lamp_q.yellow;
    assign o_NS_green  = ns_lamp_q.green;
    assign o_EW_red    = ew_lamp_q.red;
    assign o_EW_yellow = ew_lamp_q.yellow;
    assign o_EW_green  = ew_lamp_q.green;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: phase-table model compared every cycle,
// plus directed literal expectations for the timing scenarios.
module tb_traffic_phase_sequencer;

    localparam int NSG = 32;
    localparam int EWG = 16;
    localparam int YEL = 4;
    localparam int AR  = 2;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       ns_det = 1'b0;
    logic       ew_det = 1'b0;
    logic       ns_r, ns_y, ns_g, ew_r, ew_y, ew_g;
    logic [2:0] phase;
    logic [5:0] timer;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc;
    bit chk_en = 1'b0;

    traffic_phase_sequencer #(
        .NS_GREEN_CYC (NSG),
        .EW_GREEN_CYC (EWG),
        .YELLOW_CYC   (YEL),
        .ALLRED_CYC   (AR),
        .TMR_W        (6)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_NS_vehicle_detect (ns_det),
        .i_EW_vehicle_detect (ew_det),
        .o_NS_red            (ns_r),
        .o_NS_yellow         (ns_y),
        .o_NS_green          (ns_g),
        .o_EW_red            (ew_r),
        .o_EW_yellow         (ew_y),
        .o_EW_green          (ew_g),
        .o_phase             (phase),
        .o_timer             (timer)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    // Model: phase index into a duration table, unsaturated elapsed count
    function automatic int dur_of(input int ph);
        case (ph)
            0:       return NSG;
            1, 4:    return YEL;
            2, 5:    return AR;
            3:       return EWG;
            default: return 1;
        endcase
    endfunction

    function automatic logic [2:0] lamp_of(input bit grn, input bit yel);
        if (grn) return 3'b001;
        if (yel) return 3'b010;
        return 3'b100;
    endfunction

    int m_phase, m_elapsed, nx_phase, nx_elapsed;
    bit m_ns_req, m_ew_req, nx_ns, nx_ew, m_adv;

    always_comb begin
        m_adv      = (m_elapsed >= dur_of(m_phase) - 1) &&
                     ((m_phase == 0) ? m_ew_req : (m_phase == 3) ? m_ns_req : 1'b1);
        nx_phase   = m_adv ? (m_phase + 1) % 6 : m_phase;
        nx_elapsed = m_adv ? 0 : m_elapsed + 1;
        nx_ew      = ew_det || (m_ew_req && !(m_adv && nx_phase == 3));
        nx_ns      = ns_det || (m_ns_req && !(m_adv && nx_phase == 0));
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   <= 0;
            m_elapsed <= 0;
            m_ns_req  <= 1'b0;
            m_ew_req  <= 1'b0;
        end else begin
            m_phase   <= nx_phase;
            m_elapsed <= nx_elapsed;
            m_ns_req  <= nx_ns;
            m_ew_req  <= nx_ew;
        end
    end

    // Per-cycle comparison against the model and lamp safety rules
    always @(negedge clk) begin
        if (chk_en) begin
            automatic int d = dur_of(m_phase);
            automatic int et = (m_elapsed < d - 1) ? m_elapsed : d - 1;
            automatic logic [14:0] exp_v = {3'(m_phase), 6'(et),
                                            lamp_of(m_phase == 0, m_phase == 1),
                                            lamp_of(m_phase == 3, m_phase == 4)};
            automatic logic [14:0] act_v = {phase, timer, ns_r, ns_y, ns_g, ew_r, ew_y, ew_g};
            automatic bit ok = ((32'(ns_r) + 32'(ns_y) + 32'(ns_g)) == 1) &&
                               ((32'(ew_r) + 32'(ew_y) + 32'(ew_g)) == 1) &&
                               !(ns_g && ew_g) && (!ns_y || ew_r) && (!ew_y || ns_r);
            check("model", int'(act_v), int'(exp_v));
            check("lamp_rules", int'(ok), 1);
        end
    end

    // Phase-duration monitor for the continuous-demand rotation
    int rot_exp[6] = '{32, 4, 2, 16, 4, 2};
    bit rot_en = 1'b0;
    int last_ph, entry_cyc;
    always @(negedge clk) begin
        if (rot_en && int'(phase) != last_ph) begin
            check("rot_dur", cyc - entry_cyc, rot_exp[last_ph]);
            check("rot_order", int'(phase), (last_ph + 1) % 6);
            last_ph   = int'(phase);
            entry_cyc = cyc;
        end
    end

    task automatic at(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        ns_det = 1'b0;
        ew_det = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic pulse(input bit ns, input int n);
        at(n);
        if (ns) ns_det = 1'b1;
        else    ew_det = 1'b1;
        @(negedge clk);
        ns_det = 1'b0;
        ew_det = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_lamps", int'({ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}), 6'b001_100);
        check("reset_phase", int'(phase), 0);
        #2 rst_n = 1'b1;

        // Idle: NS green holds, timer saturates
        at(200);
        check("idle_phase", int'(phase), 0);
        check("idle_timer", int'(timer), 31);

        // Late EW request: latch then transition
        do_reset();
        pulse(1'b0, 100);
        check("late_req_c101", int'(ns_y), 0);
        at(102);
        check("late_req_c102", int'(ns_y), 1);

        // Early EW request: minimum green honoured
        do_reset();
        pulse(1'b0, 5);
        at(31);  check("ew_c31_phase", int'(phase), 0);
        at(32);  check("ew_c32_phase", int'(phase), 1);
        at(36);  check("ew_c36_phase", int'(phase), 2);
        at(38);  check("ew_c38_phase", int'(phase), 3);
        at(100); check("ew_hold_timer", int'({phase, timer}), (3 << 6) | 15);

        // Reset mid EW yellow with an EW request freshly latched
        pulse(1'b1, 100);
        at(102); check("ew_yel_entry", int'(phase), 4);
        pulse(1'b0, 103);
        check("pre_rst_timer", int'({phase, timer}), (4 << 6) | 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", int'({phase, timer, ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}), 6'b001_100);
        @(negedge clk);
        #2 rst_n = 1'b1;
        at(1);  check("post_rst_timer", int'(timer), 1);
        at(40); check("post_rst_no_req", int'({phase, timer}), 31);

        // Detects landing on EW green entry: both latches retained
        do_reset();
        pulse(1'b0, 5);
        at(37);
        ns_det = 1'b1;
        ew_det = 1'b1;
        @(negedge clk);
        ns_det = 1'b0;
        ew_det = 1'b0;
        check("entry_c38", int'(phase), 3);
        at(53); check("entry_c53", int'({phase, timer}), (3 << 6) | 15);
        at(54); check("entry_c54", int'(phase), 4);
        at(60); check("entry_c60", int'(phase), 0);
        at(91); check("entry_c91", int'(phase), 0);
        at(92); check("entry_c92", int'(phase), 1);

        // Continuous demand on both sides: fixed 60-cycle rotation
        @(negedge clk);
        #2 rst_n = 1'b0;
        ns_det = 1'b1;
        ew_det = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        last_ph   = 0;
        entry_cyc = 0;
        rot_en    = 1'b1;
        at(119); check("rot_c119", int'(phase), 5);
        at(120); check("rot_c120", int'({phase, timer}), 0);
        at(190);
        rot_en = 1'b0;
        ns_det = 1'b0;
        ew_det = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
